exe_unit_mc: RTL

//  Parametrised multi-cycle execute unit for the LC-3-style core. Accepts one decoded op via a

---
 rtl/exe_unit_mc.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/exe_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : exe_unit_mc
// Purpose  : Multi-cycle execute unit for an LC-3-style core. Takes one
//            decoded op over a valid/ready handshake, reads the internal
//            register file, runs ADD/AND/NOT/LEA/BR, writes back, updates
//            the NZP condition codes and returns the resolved next IP.
//            The unit is strictly serial: IDLE -> EXEC -> WB -> IDLE.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst         clock / synchronous active-high reset
//   in_valid         decoded op present
//   in_ready         unit can accept (IDLE only)
//   op               0 NOP, 1 ADD, 2 AND, 3 NOT, 4 LEA, 5 BR, 6-7 illegal
//   use_imm          ADD/AND: operand B is imm instead of reg[sr2]
//   sr1, sr2, dr     source / destination register indices
//   imm              pre-sign-extended immediate / branch offset
//   nzp_mask         BR condition mask {n,z,p}
//   ip               already-incremented IP of this op
//   done             one-cycle pulse: op retired
//   result           value written (0 for NOP/BR/illegal)
//   next_ip          resolved next IP, valid with done
//   br_taken         BR condition met, valid with done
//   illegal          op 6/7 retired, valid with done
//   nzp              current condition codes {n,z,p}
//   dbg_addr         debug register read index
//   dbg_data         combinational read of reg[dbg_addr]
// ============================================================================
module exe_unit_mc #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int REG_AW  = 3,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic              use_imm,
  input  logic [REG_AW-1:0] sr1,
  input  logic [REG_AW-1:0] sr2,
  input  logic [REG_AW-1:0] dr,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        nzp_mask,
  input  logic [ADDR_W-1:0] ip,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] next_ip,
  output logic              br_taken,
  output logic              illegal,
  output logic [2:0]        nzp,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_LEA = 3'd4;
  localparam logic [2:0] OP_BR  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state;

  // Op fields captured on accept; the input bus is free after that.
  logic [2:0]        op_q;
  logic              use_imm_q;
  logic [REG_AW-1:0] sr1_q;
  logic [REG_AW-1:0] sr2_q;
  logic [REG_AW-1:0] dr_q;
  logic [DATA_W-1:0] imm_q;
  logic [2:0]        mask_q;
  logic [ADDR_W-1:0] ip_q;

  logic [DATA_W-1:0] regs [REG_CNT];

  // Execute datapath (operates on the captured op)
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [ADDR_W-1:0] imm_a;
  logic [ADDR_W-1:0] ip_plus_imm;
  logic [DATA_W-1:0] alu_res;
  logic              alu_wr;
  logic              alu_taken;
  logic              alu_ill;
  logic [ADDR_W-1:0] alu_nip;
  logic [2:0]        alu_nzp;

  assign in_ready = (state == S_IDLE);
  assign dbg_data = regs[dbg_addr];

  assign opa         = regs[sr1_q];
  assign opb         = use_imm_q ? imm_q : regs[sr2_q];
  // Offset is brought to the IP width by truncation or zero-padding.
  assign imm_a       = ADDR_W'(imm_q);
  assign ip_plus_imm = ip_q + imm_a;

  always_comb begin
    alu_res   = '0;
    alu_wr    = 1'b0;
    alu_taken = 1'b0;
    alu_ill   = 1'b0;
    alu_nip   = ip_q;
    case (op_q)
      OP_ADD: begin
        alu_res = opa + opb;
        alu_wr  = 1'b1;
      end
      OP_AND: begin
        alu_res = opa & opb;
        alu_wr  = 1'b1;
      end
      OP_NOT: begin
        alu_res = ~opa;
        alu_wr  = 1'b1;
      end
      OP_LEA: begin
        alu_res = DATA_W'(ip_plus_imm);
        alu_wr  = 1'b1;
      end
      OP_BR: begin
        // Condition uses the codes as they stand while this op executes.
        alu_taken = |(mask_q & nzp);
        alu_nip   = alu_taken ? ip_plus_imm : ip_q;
      end
      OP_NOP: begin
        alu_res = '0;
      end
      default: begin
        alu_ill = 1'b1;
      end
    endcase
  end

  // Exactly one code bit set for any written value.
  assign alu_nzp = {alu_res[DATA_W-1],
                    (alu_res == '0),
                    (!alu_res[DATA_W-1] && (alu_res != '0))};

  // Results, write-back and the done pulse are all registered at the end of
  // EXEC so that everything is observable together during the WB cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      result    <= '0;
      next_ip   <= '0;
      br_taken  <= 1'b0;
      illegal   <= 1'b0;
      nzp       <= 3'b010;
      op_q      <= OP_NOP;
      use_imm_q <= 1'b0;
      sr1_q     <= '0;
      sr2_q     <= '0;
      dr_q      <= '0;
      imm_q     <= '0;
      mask_q    <= '0;
      ip_q      <= '0;
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            op_q      <= op;
            use_imm_q <= use_imm;
            sr1_q     <= sr1;
            sr2_q     <= sr2;
            dr_q      <= dr;
            imm_q     <= imm;
            mask_q    <= nzp_mask;
            ip_q      <= ip;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          result   <= alu_res;
          next_ip  <= alu_nip;
          br_taken <= alu_taken;
          illegal  <= alu_ill;
          done     <= 1'b1;
          if (alu_wr) begin
            regs[dr_q] <= alu_res;
            nzp        <= alu_nzp;
          end
          state <= S_WB;
        end
        S_WB: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
